qspi_flash_responder: RTL and testbench

//  Synthesizable QSPI NOR-flash device model: the responder at the far end of the QSPI bus.

---
 rtl/qspi_flash_responder_if.sv | 25 ++
 rtl/qspi_flash_responder.sv | 204 ++++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_flash_responder_if.sv
// QSPI bus between a flash controller and a flash device.
// master = controller side, slave = flash device side.
interface qspi_flash_responder_if;
    logic       qspi_cs;
    logic       qspi_sck;
    logic [3:0] qspi_din;
    logic [3:0] qspi_dout;
    logic [3:0] qspi_doe;

    modport master (
        output qspi_cs,
        output qspi_sck,
        output qspi_din,
        input  qspi_dout,
        input  qspi_doe
    );

    modport slave (
        input  qspi_cs,
        input  qspi_sck,
        input  qspi_din,
        output qspi_dout,
        output qspi_doe
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// QSPI NOR-flash device model: READ, QREAD, QPP, SE, RDSR, WREN, WRDI.
// SCK comes from the ACLK domain and is edge-detected directly.
module qspi_flash_responder #(
    parameter int MEM_BYTES   = 4096,
    parameter int PAGE_BYTES  = 256,
    parameter int ERASE_BYTES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    qspi_flash_responder_if.slave qspi,
    output logic                  busy,
    output logic                  wel
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int EW = $clog2(ERASE_BYTES);
    localparam logic [AW-1:0] PMASK = AW'(PAGE_BYTES - 1);
    localparam logic [AW-1:0] EMASK = AW'(ERASE_BYTES - 1);

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_QPP   = 8'h32;
    localparam logic [7:0] OP_SE    = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD1,
        S_STATUS, S_RD4, S_WRQ, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            sck_q;
    logic            rise, fall, frame_end, wr_en;
    logic [4:0]      cnt;
    logic [7:0]      sh, op, opc, rdata, rd_byte, wr_data;
    logic            op_vld, armed;
    logic [AW-1:0]   addr, ebase;
    logic [EW-1:0]   ecnt;
    logic [3:0]      dout_q, doe;
    // stored inverted so the all-zero power-up state reads as erased 0xFF
    logic [7:0]      mem_n [MEM_BYTES];

    assign rise      = qspi.qspi_sck & ~sck_q & ~qspi.qspi_cs;
    assign fall      = ~qspi.qspi_sck & sck_q & ~qspi.qspi_cs;
    assign frame_end = qspi.qspi_cs && (state_q != S_IDLE);
    assign opc       = {sh[6:0], qspi.qspi_din[0]};
    assign rdata     = ~mem_n[addr];
    assign rd_byte   = (state_q == S_STATUS) ? {6'b0, wel, busy} : rdata;
    assign wr_data   = {sh[3:0], qspi.qspi_din};
    assign wr_en     = (state_q == S_WRQ) && rise && cnt[0] && wel;

    assign qspi.qspi_dout = dout_q;
    assign qspi.qspi_doe  = doe;

    // state register
    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state and IO enables; cs high returns to idle from anywhere
    always_comb begin
        state_d = state_q;
        doe     = 4'b0000;
        unique case (state_q)
            S_IDLE: if (!qspi.qspi_cs) state_d = S_CMD;
            S_CMD: begin
                if (rise && cnt == 5'd7) begin
                    if (busy && opc != OP_RDSR) state_d = S_DONE;
                    else begin
                        unique case (1'b1)
                            (opc == OP_RDSR):  state_d = S_STATUS;
                            (opc == OP_READ),
                            (opc == OP_QREAD),
                            (opc == OP_QPP),
                            (opc == OP_SE):    state_d = S_ADDR;
                            default:           state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_ADDR: begin
                if (rise && cnt == 5'd23) begin
                    unique case (1'b1)
                        (op == OP_READ):  state_d = S_RD1;
                        (op == OP_QREAD): state_d = S_DUMMY;
                        (op == OP_QPP):   state_d = S_WRQ;
                        default:          state_d = S_DONE;
                    endcase
                end
            end
            S_DUMMY: if (rise && cnt == 5'd7) state_d = S_RD4;
            S_RD1, S_STATUS: doe = 4'b0010;
            S_RD4: doe = 4'b1111;
            default: ;
        endcase
        if (qspi.qspi_cs) state_d = S_IDLE;
    end

    // serial shifting, addressing and read data drive
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sck_q  <= 1'b0;
            cnt    <= '0;
            sh     <= '0;
            op     <= '0;
            op_vld <= 1'b0;
            armed  <= 1'b0;
            addr   <= '0;
            dout_q <= '0;
        end else begin
            sck_q <= qspi.qspi_sck;
            unique case (state_q)
                S_IDLE: begin
                    op_vld <= 1'b0;
                    armed  <= 1'b0;
                    dout_q <= '0;
                end
                S_CMD: if (rise) begin
                    sh  <= opc;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd7) begin
                        op     <= opc;
                        op_vld <= !busy || opc == OP_RDSR;
                    end
                end
                S_ADDR: if (rise) begin
                    addr <= {addr[AW-2:0], qspi.qspi_din[0]};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd23 && op == OP_SE) armed <= 1'b1;
                end
                S_DUMMY: if (rise) cnt <= cnt + 5'd1;
                S_RD1, S_STATUS: if (fall) begin
                    cnt <= cnt + 5'd1;
                    if (cnt[2:0] == 3'd0) begin
                        dout_q <= {2'b00, rd_byte[7], 1'b0};
                        sh     <= {rd_byte[6:0], 1'b0};
                        if (state_q == S_RD1) addr <= addr + AW'(1);
                    end else begin
                        dout_q <= {2'b00, sh[7], 1'b0};
                        sh     <= {sh[6:0], 1'b0};
                    end
                end
                S_RD4: if (fall) begin
                    cnt <= cnt + 5'd1;
                    if (!cnt[0]) begin
                        dout_q <= rdata[7:4];
                        sh     <= rdata;
                        addr   <= addr + AW'(1);
                    end else begin
                        dout_q <= sh[3:0];
                    end
                end
                S_WRQ: if (rise) begin
                    cnt <= cnt + 5'd1;
                    if (!cnt[0]) sh <= {4'b0, qspi.qspi_din};
                    else addr <= (addr & ~PMASK) | ((addr + AW'(1)) & PMASK);
                end
                default: ;
            endcase
            if (state_d != state_q) cnt <= '0;
        end
    end

    // write-enable latch and block erase sequencer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wel   <= 1'b0;
            busy  <= 1'b0;
            ecnt  <= '0;
            ebase <= '0;
        end else begin
            if (busy) begin
                ecnt <= ecnt + EW'(1);
                if (&ecnt) busy <= 1'b0;
            end
            if (frame_end && op_vld) begin
                unique case (1'b1)
                    (op == OP_WREN): wel <= 1'b1;
                    (op == OP_WRDI): wel <= 1'b0;
                    (op == OP_QPP):  wel <= 1'b0;
                    (op == OP_SE): begin
                        if (armed && wel) begin
                            busy  <= 1'b1;
                            ecnt  <= '0;
                            ebase <= addr & ~EMASK;
                            wel   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // array writes: erase fills 0xFF, program can only clear bits
    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            if (busy)       mem_n[ebase | AW'(ecnt)] <= '0;
            else if (wr_en) mem_n[addr] <= mem_n[addr] | ~wr_data;
        end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder.
// Plays the controller role on the QSPI bus.
module tb_qspi_flash_responder;
    logic ACLK = 1'b0;
    logic ARESET;
    logic busy, wel;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   busy_cyc = 0;

    qspi_flash_responder_if bus();

    qspi_flash_responder dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .qspi   (bus.slave),
        .busy   (busy),
        .wel    (wel)
    );

    always #5 ACLK = ~ACLK;

    // total cycles observed with busy high
    always @(negedge ACLK) if (busy === 1'b1) busy_cyc++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // one SCK period: present din, sample IO just before the rise
    task automatic cyc(input logic [3:0] d, output logic [3:0] q,
                       output logic [3:0] oe);
        bus.qspi_din = d;
        tick(2);
        q  = bus.qspi_dout;
        oe = bus.qspi_doe;
        bus.qspi_sck = 1'b1;
        tick(2);
        bus.qspi_sck = 1'b0;
    endtask

    task automatic cs_lo();
        bus.qspi_cs = 1'b0;
        tick(2);
    endtask

    task automatic cs_hi();
        tick(2);
        bus.qspi_cs  = 1'b1;
        bus.qspi_din = 4'h0;
        tick(4);
    endtask

    task automatic tx_bits(input logic [23:0] v, input int hi, input int n);
        logic [3:0] q, oe;
        for (int i = hi; i > hi - n; i--) cyc({3'b000, v[i]}, q, oe);
    endtask

    task automatic rx1(output logic [7:0] b, output logic oe_ok);
        logic [3:0] q, oe;
        b = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(4'h0, q, oe);
            b = {b[6:0], q[1]};
            if (oe !== 4'b0010) oe_ok = 1'b0;
        end
    endtask

    task automatic rx4(output logic [7:0] b, output logic oe_ok);
        logic [3:0] q, oe;
        b = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(4'h0, q, oe);
            b = {b[3:0], q};
            if (oe !== 4'b1111) oe_ok = 1'b0;
        end
    endtask

    task automatic op_only(input logic [7:0] op);
        cs_lo();
        tx_bits({16'h0, op}, 7, 8);
        cs_hi();
    endtask

    task automatic qpp(input logic [23:0] a, input int n,
                       input logic [7:0] b0, input logic [7:0] b1);
        logic [3:0] q, oe;
        logic [15:0] d;
        d = {b0, b1};
        cs_lo();
        tx_bits(24'h32, 7, 8);
        tx_bits(a, 23, 24);
        for (int i = 0; i < 2 * n; i++) cyc(d[15 - 4*i -: 4], q, oe);
        cs_hi();
    endtask

    task automatic read1(input logic [23:0] a, output logic [7:0] b);
        logic ok;
        cs_lo();
        tx_bits(24'h03, 7, 8);
        tx_bits(a, 23, 24);
        rx1(b, ok);
        cs_hi();
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        int         c0, n;

        ARESET = 1'b1;
        bus.qspi_cs  = 1'b1;
        bus.qspi_sck = 1'b0;
        bus.qspi_din = 4'h0;
        tick(5);
        ARESET = 1'b0;
        tick(2);

        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wel", 32'(wel), 32'h0);
        check("rst_doe", 32'(bus.qspi_doe), 32'h0);
        check("rst_dout", 32'(bus.qspi_dout), 32'h0);

        // RDSR after reset, repeated status bytes
        cs_lo();
        tx_bits(24'h05, 7, 8);
        for (int i = 0; i < 3; i++) begin
            rx1(b, ok);
            check("rdsr0_byte", 32'(b), 32'h00);
            check("rdsr0_doe", 32'(ok), 32'h1);
        end
        cs_hi();
        check("rdsr0_doe_off", 32'(bus.qspi_doe), 32'h0);

        // WREN then quad page program A5 3C at 0x10
        op_only(8'h06);
        check("wren_wel", 32'(wel), 32'h1);
        qpp(24'h000010, 2, 8'hA5, 8'h3C);
        check("qpp_wel_clr", 32'(wel), 32'h0);
        read1(24'h000010, b);
        check("rd_10", 32'(b), 32'hA5);
        read1(24'h000011, b);
        check("rd_11", 32'(b), 32'h3C);

        // QREAD with 8 dummy clocks
        cs_lo();
        tx_bits(24'h6B, 7, 8);
        tx_bits(24'h000010, 23, 24);
        tx_bits(24'h0, 7, 8);
        rx4(b, ok);
        check("qrd_b0", 32'(b), 32'hA5);
        check("qrd_doe", 32'(ok), 32'h1);
        rx4(b, ok);
        check("qrd_b1", 32'(b), 32'h3C);
        rx4(b, ok);
        check("qrd_b2", 32'(b), 32'hFF);
        cs_hi();

        // program without WREN is suppressed
        qpp(24'h000020, 1, 8'h00, 8'h00);
        read1(24'h000020, b);
        check("qpp_nowel", 32'(b), 32'hFF);

        // page wrap FF -> 00
        op_only(8'h06);
        qpp(24'h0000FF, 2, 8'h11, 8'h22);
        read1(24'h0000FF, b);
        check("pw_ff", 32'(b), 32'h11);
        read1(24'h000000, b);
        check("pw_00", 32'(b), 32'h22);
        read1(24'h000100, b);
        check("pw_100", 32'(b), 32'hFF);

        // sequential read wraps the array FFF -> 000
        cs_lo();
        tx_bits(24'h03, 7, 8);
        tx_bits(24'h000FFF, 23, 24);
        rx1(b, ok);
        check("rw_fff", 32'(b), 32'hFF);
        rx1(b, ok);
        check("rw_000", 32'(b), 32'h22);
        cs_hi();

        // seed bytes around the 0x400 block
        op_only(8'h06);
        qpp(24'h0003FF, 1, 8'h00, 8'h00);
        op_only(8'h06);
        qpp(24'h000400, 1, 8'h12, 8'h00);
        op_only(8'h06);
        qpp(24'h0007FF, 1, 8'h34, 8'h00);
        op_only(8'h06);
        qpp(24'h000800, 1, 8'h56, 8'h00);
        read1(24'h000400, b);
        check("seed_400", 32'(b), 32'h12);

        // truncated erase: no erase, wel kept
        op_only(8'h06);
        cs_lo();
        tx_bits(24'h20, 7, 8);
        tx_bits(24'h000410, 23, 12);
        cs_hi();
        tick(4);
        check("se_part_busy", 32'(busy), 32'h0);
        check("se_part_wel", 32'(wel), 32'h1);

        // full sector erase at 0x410
        cs_lo();
        tx_bits(24'h20, 7, 8);
        tx_bits(24'h000410, 23, 24);
        c0 = busy_cyc;
        cs_hi();
        check("se_busy", 32'(busy), 32'h1);
        check("se_wel_clr", 32'(wel), 32'h0);
        cs_lo();
        tx_bits(24'h05, 7, 8);
        rx1(b, ok);
        check("rdsr_busy0", 32'(b), 32'h01);
        rx1(b, ok);
        check("rdsr_busy1", 32'(b), 32'h01);
        cs_hi();
        op_only(8'h06);
        check("wren_in_busy", 32'(wel), 32'h0);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            tick(1);
            n++;
        end
        check("se_done", 32'(busy), 32'h0);
        check("se_cycles", 32'(busy_cyc - c0), 32'd1024);
        cs_lo();
        tx_bits(24'h05, 7, 8);
        rx1(b, ok);
        check("rdsr_idle", 32'(b), 32'h00);
        cs_hi();
        read1(24'h0003FF, b);
        check("se_3ff", 32'(b), 32'h00);
        read1(24'h000400, b);
        check("se_400", 32'(b), 32'hFF);
        read1(24'h0007FF, b);
        check("se_7ff", 32'(b), 32'hFF);
        read1(24'h000800, b);
        check("se_800", 32'(b), 32'h56);

        // WRDI clears the latch
        op_only(8'h06);
        check("wren2_wel", 32'(wel), 32'h1);
        op_only(8'h04);
        check("wrdi_wel", 32'(wel), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
